// File: rtl/quadratic_root_solver_pkg.sv
// ============================================================================
//  quadratic_root_solver_pkg
//  Shared rtx types and constants: fp24 format, pipeline delays, root modes.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package quadratic_root_solver_pkg;

    // fp24 = {sign, 7-bit exponent (bias 63), 16-bit mantissa}; exponent 0 is zero
    typedef logic [23:0] fp24;

    localparam int FP_BIAS    = 63;
    localparam int SQRT_DELAY = 4;
    localparam int MUL_DELAY  = 1;
    localparam int ADD_DELAY  = 2;

    typedef enum logic [1:0] {
        NEAR      = 2'd0,
        FAR       = 2'd1,
        FIRST_POS = 2'd2
    } root_mode_t;

    function automatic logic fp24_is_pos(input fp24 v);
        return (v[23] == 1'b0) && (v[22:0] != 23'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp24_add.sv
// ============================================================================
//  fp24_add
//  Two-stage fp24 adder: align on stage 1, add and normalise on stage 2.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fp24_add
    import quadratic_root_solver_pkg::*;
(
    input  logic clk,
    input  fp24  a,
    input  fp24  b,
    output fp24  y
);

    logic        w_swap;
    fp24         w_big;
    fp24         w_small;
    logic [16:0] w_sig_big;
    logic [16:0] w_sig_small;
    logic [6:0]  w_diff;
    logic [16:0] w_aligned;

    // Larger magnitude always lands in the "big" slot so the subtract never borrows out
    always_comb begin
        w_swap      = (b[22:0] > a[22:0]);
        w_big       = w_swap ? b : a;
        w_small     = w_swap ? a : b;
        w_sig_big   = (w_big[22:16]   != 7'd0) ? {1'b1, w_big[15:0]}   : 17'd0;
        w_sig_small = (w_small[22:16] != 7'd0) ? {1'b1, w_small[15:0]} : 17'd0;
        w_diff      = w_big[22:16] - w_small[22:16];
        w_aligned   = (w_diff > 7'd16) ? 17'd0 : (w_sig_small >> w_diff);
    end

    logic        r_sign;
    logic        r_sub;
    logic [6:0]  r_exp;
    logic [16:0] r_sig_big;
    logic [16:0] r_sig_small;

    always_ff @(posedge clk) begin
        r_sign      <= w_big[23];
        r_sub       <= a[23] ^ b[23];
        r_exp       <= w_big[22:16];
        r_sig_big   <= w_sig_big;
        r_sig_small <= w_aligned;
    end

    logic [17:0]       w_sum;
    logic [4:0]        w_msb;
    logic [4:0]        w_lz;
    logic [16:0]       w_norm;
    logic signed [8:0] w_exp_n;
    logic [7:0]        w_exp_ovf;
    fp24               w_y;
    logic              w_unused_bits;

    assign w_unused_bits = ^{w_norm[16], w_exp_n[8:7]};

    always_comb begin
        w_sum = r_sub ? ({1'b0, r_sig_big} - {1'b0, r_sig_small})
                      : ({1'b0, r_sig_big} + {1'b0, r_sig_small});
        w_msb = 5'd0;
        for (int i = 0; i < 17; i++) begin
            if (w_sum[i]) begin
                w_msb = 5'(i);
            end
        end
        w_lz      = 5'd16 - w_msb;
        w_norm    = w_sum[16:0] << w_lz;
        w_exp_n   = $signed({2'b00, r_exp}) - $signed({4'b0000, w_lz});
        w_exp_ovf = {1'b0, r_exp} + 8'd1;
        w_y       = '0;
        if (w_sum[17]) begin
            if (w_exp_ovf[7]) begin
                w_y = {r_sign, 7'h7F, 16'hFFFF};
            end else begin
                w_y = {r_sign, w_exp_ovf[6:0], w_sum[16:1]};
            end
        end else if ((w_sum[16:0] != 17'd0) && (w_exp_n > 9'sd0)) begin
            w_y = {r_sign, w_exp_n[6:0], w_norm[15:0]};
        end
    end

    always_ff @(posedge clk) begin
        y <= w_y;
    end

endmodule

`default_nettype wire

// File: rtl/fp24_mul.sv
// ============================================================================
//  fp24_mul
//  Single-cycle registered fp24 multiplier, truncating, flush-to-zero.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fp24_mul
    import quadratic_root_solver_pkg::*;
(
    input  logic clk,
    input  fp24  a,
    input  fp24  b,
    output fp24  y
);

    logic [33:0]       w_prod;
    logic signed [9:0] w_exp;
    fp24               w_y;
    logic              w_unused_bits;

    assign w_unused_bits = ^{w_prod[15:0], w_exp[9:7]};

    always_comb begin
        w_prod = {17'd0, 1'b1, a[15:0]} * {17'd0, 1'b1, b[15:0]};
        w_exp  = $signed({3'b000, a[22:16]}) + $signed({3'b000, b[22:16]})
               - 10'sd63 + (w_prod[33] ? 10'sd1 : 10'sd0);
        w_y    = '0;
        if ((a[22:16] != 7'd0) && (b[22:16] != 7'd0)) begin
            if (w_exp > 10'sd127) begin
                w_y = {a[23] ^ b[23], 7'h7F, 16'hFFFF};
            end else if (w_exp > 10'sd0) begin
                w_y = {a[23] ^ b[23], w_exp[6:0],
                       w_prod[33] ? w_prod[32:17] : w_prod[31:16]};
            end
        end
    end

    always_ff @(posedge clk) begin
        y <= w_y;
    end

endmodule

`default_nettype wire

// File: rtl/fp24_shift.sv
// ============================================================================
//  fp24_shift
//  Combinational scale by 2^SHIFT through the exponent field.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fp24_shift
    import quadratic_root_solver_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  fp24 a,
    output fp24 y
);

    logic signed [8:0] w_exp;
    logic              w_unused_exp;

    assign w_unused_exp = ^w_exp[8:7];

    always_comb begin
        w_exp = $signed({2'b00, a[22:16]}) + 9'(SHIFT);
        y     = '0;
        if (a[22:16] != 7'd0) begin
            if (w_exp > 9'sd127) begin
                y = {a[23], 7'h7F, 16'hFFFF};
            end else if (w_exp > 9'sd0) begin
                y = {a[23], w_exp[6:0], a[15:0]};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp24_sqrt.sv
// ============================================================================
//  fp24_sqrt
//  fp24 square root of |a| (digit-by-digit, exact on perfect squares), DELAY cycles.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fp24_sqrt
    import quadratic_root_solver_pkg::*;
#(
    parameter int DELAY = SQRT_DELAY
) (
    input  logic clk,
    input  fp24  a,
    output fp24  y
);

    logic [16:0] w_sig;
    logic [33:0] w_rad;
    logic [7:0]  w_exp_sum;
    logic [19:0] w_rem;
    logic [19:0] w_trial;
    logic [16:0] w_root;
    fp24         w_y;
    logic        w_unused_bits;

    assign w_unused_bits = ^{a[23], w_exp_sum[7], w_root[16]};

    // An even biased exponent means an odd unbiased one, so fold one factor of 2 into the radicand
    always_comb begin
        w_sig     = {1'b1, a[15:0]};
        w_rad     = a[16] ? {1'b0, w_sig, 16'd0} : {w_sig, 17'd0};
        w_exp_sum = ({1'b0, a[22:16]} + 8'd63) >> 1;
        w_rem     = '0;
        w_trial   = '0;
        w_root    = '0;
        for (int i = 16; i >= 0; i--) begin
            w_rem   = {w_rem[17:0], w_rad[2*i +: 2]};
            w_trial = {1'b0, w_root, 2'b01};
            if (w_rem >= w_trial) begin
                w_rem  = w_rem - w_trial;
                w_root = {w_root[15:0], 1'b1};
            end else begin
                w_root = {w_root[15:0], 1'b0};
            end
        end
        w_y = (a[22:16] == 7'd0) ? '0 : {1'b0, w_exp_sum[6:0], w_root[15:0]};
    end

    pipeline #(
        .WIDTH (24),
        .DEPTH (DELAY),
        .RESET (1'b0)
    ) u_delay (
        .clk (clk),
        .rst (1'b0),
        .d   (w_y),
        .q   (y)
    );

endmodule

`default_nettype wire

// File: rtl/pipeline.sv
// ============================================================================
//  pipeline
//  Fixed-depth register delay line with optional synchronous reset.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1,
    parameter bit RESET = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_ports;
            assign w_unused_ports = clk ^ rst;
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (RESET && rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/quadratic_root_select.sv
// ============================================================================
//  quadratic_root_select
//  Registered root selection and hit qualification for the solver output.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module quadratic_root_select
    import quadratic_root_solver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  fp24        near,
    input  fp24        far,
    input  logic       d_neg,
    input  root_mode_t mode,
    output fp24        x_out,
    output logic       hit
);

    logic w_near_pos;
    logic w_far_pos;
    fp24  w_pick;
    logic w_pick_pos;
    logic w_hit;

    always_comb begin
        w_near_pos = fp24_is_pos(near);
        w_far_pos  = fp24_is_pos(far);
        w_pick     = near;
        w_pick_pos = w_near_pos;
        case (mode)
            FAR: begin
                w_pick     = far;
                w_pick_pos = w_far_pos;
            end
            FIRST_POS: begin
                if (!w_near_pos && w_far_pos) begin
                    w_pick     = far;
                    w_pick_pos = 1'b1;
                end
            end
            default: begin
                w_pick     = near;
                w_pick_pos = w_near_pos;
            end
        endcase
        w_hit = !d_neg && ((mode != FIRST_POS) || w_pick_pos);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_out <= '0;
            hit   <= 1'b0;
        end else if (valid) begin
            x_out <= w_pick;
            hit   <= w_hit;
        end
    end

endmodule

`default_nettype wire

// File: rtl/quadratic_root_solver.sv
// ============================================================================
//  quadratic_root_solver
//  Pipelined fp24 solver for x^2 + b*x + c = 0 with per-sample root selection.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module quadratic_root_solver
    import quadratic_root_solver_pkg::*;
#(
    parameter int TAG_WIDTH = 8,
    parameter int OCC_WIDTH = $clog2(SQRT_DELAY + 7)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  fp24                  b,
    input  fp24                  c,
    input  root_mode_t           mode,
    input  logic [TAG_WIDTH-1:0] tag,
    output logic                 out_valid,
    output fp24                  x_out,
    output fp24                  x_near,
    output fp24                  x_far,
    output logic                 hit,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic [OCC_WIDTH-1:0] occupancy,
    output logic                 idle
);

    localparam int LATENCY  = MUL_DELAY + ADD_DELAY + SQRT_DELAY + ADD_DELAY + 1;
    localparam int SIDE_DLY = LATENCY - 1;

    fp24 w_bb;
    fp24 w_c4;
    fp24 w_c4_d;
    fp24 w_disc;
    fp24 w_root;
    fp24 w_negb_d;
    fp24 w_num_near;
    fp24 w_num_far;
    fp24 w_near;
    fp24 w_far;
    logic                 w_d_neg;
    logic [1:0]           w_mode_d;
    logic [TAG_WIDTH-1:0] w_tag_d;
    logic                 w_valid_d;

    fp24_mul u_bb (.clk(clk), .a(b), .b(b), .y(w_bb));

    fp24_shift #(.SHIFT(2)) u_c4 (.a(c), .y(w_c4));

    pipeline #(.WIDTH(24), .DEPTH(MUL_DELAY), .RESET(1'b0)) u_c4_pipe (
        .clk(clk), .rst(rst), .d(w_c4), .q(w_c4_d)
    );

    fp24_add u_disc (.clk(clk), .a(w_bb), .b({~w_c4_d[23], w_c4_d[22:0]}), .y(w_disc));

    fp24_sqrt #(.DELAY(SQRT_DELAY)) u_sqrt (.clk(clk), .a(w_disc), .y(w_root));

    pipeline #(.WIDTH(24), .DEPTH(MUL_DELAY + ADD_DELAY + SQRT_DELAY), .RESET(1'b0)) u_negb_pipe (
        .clk(clk), .rst(rst), .d({~b[23], b[22:0]}), .q(w_negb_d)
    );

    fp24_add u_num_near (.clk(clk), .a(w_negb_d), .b({~w_root[23], w_root[22:0]}), .y(w_num_near));
    fp24_add u_num_far  (.clk(clk), .a(w_negb_d), .b(w_root), .y(w_num_far));

    fp24_shift #(.SHIFT(-1)) u_half_near (.a(w_num_near), .y(w_near));
    fp24_shift #(.SHIFT(-1)) u_half_far  (.a(w_num_far),  .y(w_far));

    // Sideband pipes are timed so every signal meets the roots at the select stage
    pipeline #(.WIDTH(1), .DEPTH(SQRT_DELAY + ADD_DELAY), .RESET(1'b0)) u_dsign_pipe (
        .clk(clk), .rst(rst), .d(w_disc[23]), .q(w_d_neg)
    );

    pipeline #(.WIDTH(2), .DEPTH(SIDE_DLY), .RESET(1'b0)) u_mode_pipe (
        .clk(clk), .rst(rst), .d(mode), .q(w_mode_d)
    );

    pipeline #(.WIDTH(TAG_WIDTH), .DEPTH(SIDE_DLY), .RESET(1'b0)) u_tag_pipe (
        .clk(clk), .rst(rst), .d(tag), .q(w_tag_d)
    );

    pipeline #(.WIDTH(1), .DEPTH(SIDE_DLY), .RESET(1'b1)) u_valid_pipe (
        .clk(clk), .rst(rst), .d(in_valid), .q(w_valid_d)
    );

    quadratic_root_select u_select (
        .clk   (clk),
        .rst   (rst),
        .valid (w_valid_d),
        .near  (w_near),
        .far   (w_far),
        .d_neg (w_d_neg),
        .mode  (root_mode_t'(w_mode_d)),
        .x_out (x_out),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            x_near    <= '0;
            x_far     <= '0;
            tag_out   <= '0;
        end else begin
            out_valid <= w_valid_d;
            if (w_valid_d) begin
                x_near  <= w_near;
                x_far   <= w_far;
                tag_out <= w_tag_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else if (in_valid && !out_valid) begin
            occupancy <= occupancy + OCC_WIDTH'(1);
        end else if (!in_valid && out_valid) begin
            occupancy <= occupancy - OCC_WIDTH'(1);
        end
    end

    assign idle = (occupancy == '0);

endmodule

`default_nettype wire
